address_gen_stage: RTL and testbench

Address-generation (AG) pipe stage between decode stage 2 and the memory stage. It forms the effective and linear memory address from base, scaled index, displacement and segment. It detects read-after-write hazards against in-flight AG/EX/ME destinations and optionally flags segment-limit violations. Results are captured in the internal AG→ME pipeline register.

---
 rtl/agen_pkg.sv | 23 ++
 rtl/agen_dep_check.sv | 29 ++
 rtl/address_gen_stage.sv | 133 +++++++++++++
 tb/tb_address_gen_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/agen_pkg.sv
// Shared constants and helpers for the address-generation stage.
package agen_pkg;

  localparam logic [2:0] ES = 3'd0;
  localparam logic [2:0] CS = 3'd1;
  localparam logic [2:0] SS = 3'd2;
  localparam logic [2:0] DS = 3'd3;
  localparam logic [2:0] FS = 3'd4;
  localparam logic [2:0] GS = 3'd5;

  localparam logic [2:0] REG_ESP = 3'b100;

  // Indexed by segment ID; entry 7 first. Only FS has the short limit.
  localparam logic [7:0][31:0] SEG_LIMIT = {
    32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0FFF,
    32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF
  };

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/agen_dep_check.sv
// Read-after-write hazard compare of AG source IDs against AG/EX/ME destinations (pure combinational).
module agen_dep_check (
  input  logic [2:0]      sr1,
  input  logic [2:0]      sib_i,
  input  logic [2:0]      seg1,
  input  logic            sr1_used,
  input  logic            sib_used,
  input  logic            seg_used,
  input  logic [2:0][2:0] gpr_drid,
  input  logic [2:0]      gpr_ld,
  input  logic [2:0][2:0] seg_drid,
  input  logic [2:0]      seg_ld,
  output logic            gpr_hazard,
  output logic            seg_hazard
);

  always_comb begin
    gpr_hazard = 1'b0;
    seg_hazard = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (gpr_ld[k] && ((sr1_used && (sr1 == gpr_drid[k])) ||
                        (sib_used && (sib_i == gpr_drid[k]))))
        gpr_hazard = 1'b1;
      if (seg_ld[k] && seg_used && (seg1 == seg_drid[k]))
        seg_hazard = 1'b1;
    end
  end

endmodule

// File: rtl/address_gen_stage.sv
// AG pipe stage: effective/linear address, RAW hazard stall, AG->ME register held while LD_ME=0.
// AGEN_SEG_LIMIT_CHECK_EN builds the segment-limit comparator; otherwise ME_SEG_EXC is tied 0.
module address_gen_stage
  import agen_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic        LD_ME,
  input  logic        V_IN,
  input  logic [31:0] EIP_IN,
  input  logic [1:0]  DATA_SIZE,
  input  logic        BASE_REG_EN,
  input  logic        SIB_EN,
  input  logic        DISP_EN,
  input  logic [1:0]  SIB_S,
  input  logic [2:0]  SR1,
  input  logic [2:0]  SIB_I,
  input  logic [2:0]  SEG1,
  input  logic        SR1_NEEDED,
  input  logic        SEG1_NEEDED,
  input  logic        MEM_RD,
  input  logic        MEM_WR,
  input  logic [31:0] DISP32,
  input  logic [31:0] IMM32,
  input  logic [31:0] SR1_DATA,
  input  logic [31:0] SIB_I_DATA,
  input  logic [15:0] SEG1_DATA,
  input  logic [2:0]  AG_DRID1,
  input  logic [2:0]  EX_DRID1,
  input  logic [2:0]  ME_DRID1,
  input  logic [2:0]  AG_DRID2,
  input  logic [2:0]  EX_DRID2,
  input  logic [2:0]  ME_DRID2,
  input  logic        V_AG_LD_GPR1,
  input  logic        V_EX_LD_GPR1,
  input  logic        V_ME_LD_GPR1,
  input  logic        V_AG_LD_SEG,
  input  logic        V_EX_LD_SEG,
  input  logic        V_ME_LD_SEG,
  output logic [2:0]  AG_SR1_OUT,
  output logic [2:0]  AG_SIB_I_OUT,
  output logic [2:0]  AG_SEG1_OUT,
  output logic        DEP_STALL,
  output logic        ME_V,
  output logic [31:0] ME_EIP,
  output logic [31:0] ME_ADDR,
  output logic [31:0] ME_A,
  output logic [31:0] ME_B,
  output logic        ME_MEM_RD,
  output logic        ME_MEM_WR,
  output logic        ME_SEG_EXC
);

  logic [31:0] base_term;
  logic [31:0] index_term;
  logic [31:0] disp_term;
  logic [31:0] ea;
  logic [31:0] lin_addr;
  logic        gpr_hazard;
  logic        seg_hazard;
  logic        issue;

  assign AG_SR1_OUT   = SR1;
  assign AG_SIB_I_OUT = SIB_I;
  assign AG_SEG1_OUT  = SEG1;

  // An ESP index encoding means "no index".
  assign base_term  = BASE_REG_EN ? SR1_DATA : 32'd0;
  assign index_term = (SIB_EN && (SIB_I != REG_ESP)) ? (SIB_I_DATA << SIB_S) : 32'd0;
  assign disp_term  = DISP_EN ? DISP32 : 32'd0;
  assign ea         = base_term + index_term + disp_term;
  assign lin_addr   = {SEG1_DATA, 16'h0000} + ea;

  agen_dep_check u_dep_check (
    .sr1        (SR1),
    .sib_i      (SIB_I),
    .seg1       (SEG1),
    .sr1_used   (SR1_NEEDED | BASE_REG_EN),
    .sib_used   (SIB_EN),
    .seg_used   (SEG1_NEEDED),
    .gpr_drid   ({ME_DRID1, EX_DRID1, AG_DRID1}),
    .gpr_ld     ({V_ME_LD_GPR1, V_EX_LD_GPR1, V_AG_LD_GPR1}),
    .seg_drid   ({ME_DRID2, EX_DRID2, AG_DRID2}),
    .seg_ld     ({V_ME_LD_SEG, V_EX_LD_SEG, V_AG_LD_SEG}),
    .gpr_hazard (gpr_hazard),
    .seg_hazard (seg_hazard)
  );

  assign DEP_STALL = V_IN & (gpr_hazard | seg_hazard);
  assign issue     = V_IN & ~DEP_STALL;

  // Bubbles still load the datapath fields; only the control bits are forced low.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ME_V      <= 1'b0;
      ME_EIP    <= 32'd0;
      ME_ADDR   <= 32'd0;
      ME_A      <= 32'd0;
      ME_B      <= 32'd0;
      ME_MEM_RD <= 1'b0;
      ME_MEM_WR <= 1'b0;
    end else if (LD_ME) begin
      ME_V      <= issue;
      ME_EIP    <= EIP_IN;
      ME_ADDR   <= lin_addr;
      ME_A      <= SR1_DATA;
      ME_B      <= IMM32;
      ME_MEM_RD <= issue & MEM_RD;
      ME_MEM_WR <= issue & MEM_WR;
    end
  end

`ifdef AGEN_SEG_LIMIT_CHECK_EN
  logic [32:0] ea_last;
  logic        seg_exc;

  // 33-bit so a wrap past 2^32 counts as exceeding the limit.
  assign ea_last = {1'b0, ea} + {29'd0, size_bytes(DATA_SIZE)} - 33'd1;
  assign seg_exc = (MEM_RD | MEM_WR) & V_IN & (ea_last > {1'b0, SEG_LIMIT[SEG1]});

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)
      ME_SEG_EXC <= 1'b0;
    else if (LD_ME)
      ME_SEG_EXC <= issue & seg_exc;
  end
`else
  logic unused_size;
  assign unused_size = ^DATA_SIZE;
  assign ME_SEG_EXC  = 1'b0;
`endif

endmodule

// File: tb/tb_address_gen_stage.sv
// Randomized and directed bench for address_gen_stage against an arithmetic reference model.
module tb_address_gen_stage;

  logic        clk, clr, ld_me, v_in;
  logic [31:0] eip_in;
  logic [1:0]  data_size, sib_s;
  logic        base_reg_en, sib_en, disp_en;
  logic [2:0]  sr1, sib_i, seg1;
  logic        sr1_needed, seg1_needed, mem_rd, mem_wr;
  logic [31:0] disp32, imm32, sr1_data, sib_i_data;
  logic [15:0] seg1_data;
  logic [2:0]  ag_drid1, ex_drid1, me_drid1, ag_drid2, ex_drid2, me_drid2;
  logic        v_ag_gpr, v_ex_gpr, v_me_gpr, v_ag_seg, v_ex_seg, v_me_seg;

  logic [2:0]  ag_sr1_out, ag_sib_i_out, ag_seg1_out;
  logic        dep_stall, me_v, me_mem_rd, me_mem_wr, me_seg_exc;
  logic [31:0] me_eip, me_addr, me_a, me_b;

  // Reference state of the AG->ME register.
  logic        e_v, e_rd, e_wr, e_exc;
  logic [31:0] e_eip, e_addr, e_a, e_b;

  int checks = 0;
  int failures = 0;

`ifdef AGEN_SEG_LIMIT_CHECK_EN
  localparam bit LIMIT_CHECK = 1'b1;
`else
  localparam bit LIMIT_CHECK = 1'b0;
`endif

  address_gen_stage dut (
    .CLK(clk), .CLR(clr), .LD_ME(ld_me), .V_IN(v_in), .EIP_IN(eip_in),
    .DATA_SIZE(data_size), .BASE_REG_EN(base_reg_en), .SIB_EN(sib_en), .DISP_EN(disp_en),
    .SIB_S(sib_s), .SR1(sr1), .SIB_I(sib_i), .SEG1(seg1),
    .SR1_NEEDED(sr1_needed), .SEG1_NEEDED(seg1_needed), .MEM_RD(mem_rd), .MEM_WR(mem_wr),
    .DISP32(disp32), .IMM32(imm32), .SR1_DATA(sr1_data), .SIB_I_DATA(sib_i_data),
    .SEG1_DATA(seg1_data),
    .AG_DRID1(ag_drid1), .EX_DRID1(ex_drid1), .ME_DRID1(me_drid1),
    .AG_DRID2(ag_drid2), .EX_DRID2(ex_drid2), .ME_DRID2(me_drid2),
    .V_AG_LD_GPR1(v_ag_gpr), .V_EX_LD_GPR1(v_ex_gpr), .V_ME_LD_GPR1(v_me_gpr),
    .V_AG_LD_SEG(v_ag_seg), .V_EX_LD_SEG(v_ex_seg), .V_ME_LD_SEG(v_me_seg),
    .AG_SR1_OUT(ag_sr1_out), .AG_SIB_I_OUT(ag_sib_i_out), .AG_SEG1_OUT(ag_seg1_out),
    .DEP_STALL(dep_stall), .ME_V(me_v), .ME_EIP(me_eip), .ME_ADDR(me_addr),
    .ME_A(me_a), .ME_B(me_b), .ME_MEM_RD(me_mem_rd), .ME_MEM_WR(me_mem_wr),
    .ME_SEG_EXC(me_seg_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_ea();
    longint unsigned s, t;
    s = 0;
    if (base_reg_en) s = s + sr1_data;
    if (sib_en && sib_i != 3'd4) begin
      t = sib_i_data;
      s = s + t * (64'd1 << sib_s);
    end
    if (disp_en) s = s + disp32;
    return s[31:0];
  endfunction

  function automatic logic [31:0] m_lin();
    longint unsigned l;
    l = seg1_data;
    l = l * 65536 + m_ea();
    return l[31:0];
  endfunction

  function automatic bit m_exc();
    longint unsigned last, lim;
    last = m_ea();
    last = last + (64'd1 << data_size) - 1;
    lim  = (seg1 == 3'd4) ? 64'h0FFF : 64'hFFFF;
    return LIMIT_CHECK && (mem_rd || mem_wr) && v_in && (last > lim);
  endfunction

  function automatic bit m_stall();
    logic [2:0] d1 [3];
    logic [2:0] d2 [3];
    bit vg [3];
    bit vs [3];
    bit hz;
    d1 = '{ag_drid1, ex_drid1, me_drid1};
    d2 = '{ag_drid2, ex_drid2, me_drid2};
    vg = '{v_ag_gpr, v_ex_gpr, v_me_gpr};
    vs = '{v_ag_seg, v_ex_seg, v_me_seg};
    hz = 0;
    for (int k = 0; k < 3; k++) begin
      if (vg[k] && (sr1_needed || base_reg_en) && sr1 == d1[k]) hz = 1;
      if (vg[k] && sib_en && sib_i == d1[k]) hz = 1;
      if (vs[k] && seg1_needed && seg1 == d2[k]) hz = 1;
    end
    return v_in && hz;
  endfunction

  task automatic clear_model();
    e_v = 0; e_rd = 0; e_wr = 0; e_exc = 0;
    e_eip = 0; e_addr = 0; e_a = 0; e_b = 0;
  endtask

  task automatic clear_inputs();
    ld_me = 1; v_in = 0; eip_in = 0; data_size = 0; sib_s = 0;
    base_reg_en = 0; sib_en = 0; disp_en = 0; sr1 = 0; sib_i = 0; seg1 = 0;
    sr1_needed = 0; seg1_needed = 0; mem_rd = 0; mem_wr = 0;
    disp32 = 0; imm32 = 0; sr1_data = 0; sib_i_data = 0; seg1_data = 0;
    ag_drid1 = 0; ex_drid1 = 0; me_drid1 = 0; ag_drid2 = 0; ex_drid2 = 0; me_drid2 = 0;
    v_ag_gpr = 0; v_ex_gpr = 0; v_me_gpr = 0; v_ag_seg = 0; v_ex_seg = 0; v_me_seg = 0;
  endtask

  task automatic check_me(input string tag);
    check_eq({tag, ".me_v"}, me_v, e_v);
    check_eq({tag, ".me_eip"}, me_eip, e_eip);
    check_eq({tag, ".me_addr"}, me_addr, e_addr);
    check_eq({tag, ".me_a"}, me_a, e_a);
    check_eq({tag, ".me_b"}, me_b, e_b);
    check_eq({tag, ".me_rd"}, me_mem_rd, e_rd);
    check_eq({tag, ".me_wr"}, me_mem_wr, e_wr);
    check_eq({tag, ".me_exc"}, me_seg_exc, e_exc);
  endtask

  // Inputs are already applied; check combinational outputs, clock once, check registers.
  task automatic step(input string tag);
    bit stall, go;
    #1;
    stall = m_stall();
    check_eq({tag, ".stall"}, dep_stall, stall);
    check_eq({tag, ".ids"}, {ag_sr1_out, ag_sib_i_out, ag_seg1_out}, {sr1, sib_i, seg1});
    if (ld_me) begin
      go     = v_in && !stall;
      e_v    = go;
      e_rd   = go && mem_rd;
      e_wr   = go && mem_wr;
      e_exc  = go && m_exc();
      e_eip  = eip_in;
      e_addr = m_lin();
      e_a    = sr1_data;
      e_b    = imm32;
    end
    @(posedge clk);
    #1;
    check_me(tag);
  endtask

  task automatic randomize_inputs();
    ld_me       = ($urandom_range(0, 3) != 0);
    v_in        = ($urandom_range(0, 4) != 0);
    eip_in      = $urandom;
    data_size   = 2'($urandom_range(0, 3));
    sib_s       = 2'($urandom_range(0, 3));
    base_reg_en = 1'($urandom);
    sib_en      = 1'($urandom);
    disp_en     = 1'($urandom);
    sr1         = 3'($urandom_range(0, 7));
    sib_i       = 3'($urandom_range(0, 7));
    seg1        = 3'($urandom_range(0, 7));
    sr1_needed  = 1'($urandom);
    seg1_needed = 1'($urandom);
    mem_rd      = 1'($urandom);
    mem_wr      = 1'($urandom);
    imm32       = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      sr1_data = $urandom_range(0, 16'h2000); sib_i_data = $urandom_range(0, 16'h800);
      disp32   = $urandom_range(0, 16'h1000); seg1_data  = 16'($urandom_range(0, 3));
    end else begin
      sr1_data = $urandom; sib_i_data = $urandom; disp32 = $urandom; seg1_data = 16'($urandom);
    end
    ag_drid1 = 3'($urandom_range(0, 7)); ex_drid1 = 3'($urandom_range(0, 7));
    me_drid1 = 3'($urandom_range(0, 7)); ag_drid2 = 3'($urandom_range(0, 7));
    ex_drid2 = 3'($urandom_range(0, 7)); me_drid2 = 3'($urandom_range(0, 7));
    v_ag_gpr = ($urandom_range(0, 3) == 0); v_ex_gpr = ($urandom_range(0, 3) == 0);
    v_me_gpr = ($urandom_range(0, 3) == 0); v_ag_seg = ($urandom_range(0, 3) == 0);
    v_ex_seg = ($urandom_range(0, 3) == 0); v_me_seg = ($urandom_range(0, 3) == 0);
  endtask

  task automatic set_addr_case();
    clear_inputs();
    v_in = 1; eip_in = 32'h0000_1000; base_reg_en = 1; sr1 = 3'd0; sr1_data = 32'h100;
    sib_en = 1; sib_i = 3'd1; sib_i_data = 32'h10; sib_s = 2'd2;
    disp_en = 1; disp32 = 32'h8; seg1_data = 16'h0001; imm32 = 32'hCAFE_0001;
  endtask

  logic [31:0] held_addr;

  initial begin
    clear_inputs();
    clear_model();
    clr = 0;

    // Reset dominates even with a valid load pending on clock edges.
    set_addr_case();
    repeat (2) @(posedge clk);
    #1;
    check_me("reset");

    clr = 1;
    step("addr_basic");
    check_eq("addr_basic.const", me_addr, 32'h0001_0148);
    check_eq("addr_basic.v", me_v, 1'b1);

    set_addr_case();
    sib_i = 3'd4;
    step("addr_esp");
    check_eq("addr_esp.const", me_addr, 32'h0001_0108);

    clear_inputs();
    v_in = 1; sr1 = 3'd3; sr1_needed = 1; ex_drid1 = 3'd3; v_ex_gpr = 1;
    step("hazard_on");
    check_eq("hazard_on.const", {dep_stall, me_v}, 2'b10);
    v_ex_gpr = 0;
    step("hazard_off");
    check_eq("hazard_off.const", {dep_stall, me_v}, 2'b01);

    clear_inputs();
    v_in = 1; seg1 = 3'd4; mem_rd = 1; data_size = 2'b01; base_reg_en = 1; sr1_data = 32'h0FFE;
    step("limit_in");
    check_eq("limit_in.const", me_seg_exc, 1'b0);
    sr1_data = 32'h0FFF;
    step("limit_over");
    check_eq("limit_over.const", me_seg_exc, LIMIT_CHECK);

    set_addr_case();
    step("hold_load");
    held_addr = me_addr;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      ld_me = 0;
      step("hold");
    end
    check_eq("hold.addr", me_addr, held_addr);

    // Asynchronous reset between edges, while stalled and held.
    set_addr_case();
    step("pre_reset");
    v_ex_gpr = 1; ex_drid1 = 3'd0; ld_me = 0;
    clr = 0;
    #1;
    clear_model();
    check_me("async_reset");
    clr = 1;
    step("post_reset");

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
